// File: rtl/mdio_master.sv
// MDIO (Clause 22) management master: sends one 64-bit read/write frame per start request.
// Optional MDIO_TA_CHECK_EN adds rd_err, flagging a read whose second turnaround bit was not 0.
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
`ifdef MDIO_TA_CHECK_EN
    output logic        rd_err,
`endif
    input  logic        mdio_i
);

    typedef enum logic {IDLE, FRAME} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_reg, state_next;
    logic [7:0]  div_reg, div_next;
    logic [5:0]  bit_reg, bit_next;
    logic [5:0]  bit_inc;
    logic        mdc_reg, mdc_next;
    logic        mdio_o_reg, mdio_o_next;
    logic        mdio_oe_reg, mdio_oe_next;
    logic        done_reg, done_next;
    logic        rw_reg, rw_next;
    // Frame bits still to send after the one currently on mdio_o
    logic [62:0] frame_reg, frame_next;
    logic [14:0] rx_reg, rx_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        sync1_reg, sync2_reg;
`ifdef MDIO_TA_CHECK_EN
    logic        ta_reg, ta_next;
    logic        rd_err_reg, rd_err_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            bit_reg     <= '0;
            mdc_reg     <= 1'b0;
            mdio_o_reg  <= 1'b1;
            mdio_oe_reg <= 1'b0;
            done_reg    <= 1'b0;
            rw_reg      <= 1'b0;
            frame_reg   <= '1;
            rx_reg      <= '0;
            rdata_reg   <= '0;
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
`ifdef MDIO_TA_CHECK_EN
            ta_reg      <= 1'b0;
            rd_err_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_reg     <= bit_next;
            mdc_reg     <= mdc_next;
            mdio_o_reg  <= mdio_o_next;
            mdio_oe_reg <= mdio_oe_next;
            done_reg    <= done_next;
            rw_reg      <= rw_next;
            frame_reg   <= frame_next;
            rx_reg      <= rx_next;
            rdata_reg   <= rdata_next;
            sync1_reg   <= mdio_i;
            sync2_reg   <= sync1_reg;
`ifdef MDIO_TA_CHECK_EN
            ta_reg      <= ta_next;
            rd_err_reg  <= rd_err_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        bit_next     = bit_reg;
        bit_inc      = bit_reg + 6'd1;
        mdc_next     = mdc_reg;
        mdio_o_next  = mdio_o_reg;
        mdio_oe_next = mdio_oe_reg;
        done_next    = 1'b0;
        rw_next      = rw_reg;
        frame_next   = frame_reg;
        rx_next      = rx_reg;
        rdata_next   = rdata_reg;
`ifdef MDIO_TA_CHECK_EN
        ta_next      = ta_reg;
        rd_err_next  = rd_err_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                div_next     = '0;
                bit_next     = '0;
                mdc_next     = 1'b0;
                mdio_o_next  = 1'b1;
                mdio_oe_next = 1'b0;
                if (start) begin
                    state_next   = FRAME;
                    rw_next      = rw;
                    mdio_oe_next = 1'b1;
                    // Bit 0 (first preamble '1') goes straight to mdio_o; bits 1..63 queue here
                    frame_next   = {31'h7FFF_FFFF, 2'b01, (rw ? 2'b10 : 2'b01),
                                    phy_addr, reg_addr, 2'b10, wdata};
                end
            end
            FRAME: begin
                if (div_reg != DIV_LAST) begin
                    div_next = div_reg + 8'd1;
                end else begin
                    div_next = '0;
                    if (!mdc_reg) begin
                        mdc_next = 1'b1;
                    end else begin
                        // Last clk of the high phase: sample the PHY, then close the bit
                        mdc_next = 1'b0;
                        rx_next  = {rx_reg[13:0], sync2_reg};
`ifdef MDIO_TA_CHECK_EN
                        if (bit_reg == 6'd47) begin
                            ta_next = sync2_reg;
                        end
`endif
                        if (bit_reg == 6'd63) begin
                            state_next   = IDLE;
                            done_next    = 1'b1;
                            bit_next     = '0;
                            mdio_o_next  = 1'b1;
                            mdio_oe_next = 1'b0;
                            if (rw_reg) begin
                                rdata_next = {rx_reg, sync2_reg};
`ifdef MDIO_TA_CHECK_EN
                                rd_err_next = ta_reg;
`endif
                            end
                        end else begin
                            bit_next     = bit_inc;
                            mdio_o_next  = frame_reg[62];
                            frame_next   = {frame_reg[61:0], 1'b1};
                            mdio_oe_next = !(rw_reg && (bit_inc >= 6'd46));
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state_reg == FRAME);
    assign done    = done_reg;
    assign rdata   = rdata_reg;
    assign mdc     = mdc_reg;
    assign mdio_o  = mdio_o_reg;
    assign mdio_oe = mdio_oe_reg;
`ifdef MDIO_TA_CHECK_EN
    assign rd_err  = rd_err_reg;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: stimulus pushes expected frames, a monitor/PHY model
// captures bits on mdc rising edges and checks each frame at its done pulse.
module tb_mdio_master;

    localparam int CLK_DIV = 4;
    localparam int FRAME_CYC = 128 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rw;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;
`ifdef MDIO_TA_CHECK_EN
    logic        rd_err;
`endif

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .phy_addr (phy_addr),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .mdc      (mdc),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
`ifdef MDIO_TA_CHECK_EN
        .rd_err   (rd_err),
`endif
        .mdio_i   (mdio_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] bits;
        logic [63:0] oe;
        logic [15:0] rdata;
        logic        rd_err;
        int          start_cyc;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_rdata = '0;
    logic        model_rderr = 1'b0;
    logic [63:0] phy_bits = '1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor and PHY model
    logic [63:0] cap_o, cap_oe;
    int          cnt = 0;
    logic        prev_busy = 1'b0, prev_mdc = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame: got frame start at cycle %0d, expected none", cyc);
            end else begin
                chk("start_cycle", 64'(cyc), 64'(sb_q[0].start_cyc));
                chk("start_oe", 64'(mdio_oe), 64'd1);
                chk("start_o", 64'(mdio_o), 64'd1);
            end
        end
        if (busy === 1'b1) begin
            if (mdc === 1'b1 && prev_mdc !== 1'b1) begin
                if (cnt < 64) begin
                    cap_o[63-cnt]  = mdio_o;
                    cap_oe[63-cnt] = mdio_oe;
                end
                cnt++;
            end
            if (mdc === 1'b0 && prev_mdc === 1'b1 && cnt < 64) begin
                mdio_i = phy_bits[63-cnt];
            end
        end
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("bit_count", 64'(cnt), 64'd64);
                chk("frame_bits", cap_o & e.oe, e.bits & e.oe);
                chk("frame_oe", cap_oe, e.oe);
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                chk("rdata", 64'(rdata), 64'(e.rdata));
                chk("done_idle", {60'd0, busy, mdc, mdio_oe, mdio_o}, 64'h1);
`ifdef MDIO_TA_CHECK_EN
                chk("rd_err", 64'(rd_err), 64'(e.rd_err));
`endif
                $display("frame done cycle=%0d bits=%h rdata=%h", cyc, cap_o, rdata);
            end
        end
        if (busy !== 1'b1) begin
            cnt    = 0;
            mdio_i = 1'b1;
            cap_o  = '0;
            cap_oe = '0;
        end
        prev_busy = busy;
        prev_mdc  = mdc;
    end

    task automatic issue(input logic r, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input logic [15:0] pd, input logic ta2);
        exp_t e;
        rw = r; phy_addr = pa; reg_addr = ra; wdata = wd; start = 1'b1;
        e.bits = {32'hFFFF_FFFF, 2'b01, (r ? 2'b10 : 2'b01), pa, ra, 2'b10, wd};
        e.oe   = r ? {{46{1'b1}}, {18{1'b0}}} : {64{1'b1}};
        if (r) begin
            model_rdata = pd;
            model_rderr = ta2;
            phy_bits    = {{47{1'b1}}, ta2, pd};
        end else begin
            phy_bits    = '1;
        end
        e.rdata     = model_rdata;
        e.rd_err    = model_rderr;
        e.start_cyc = cyc + 1;
        e.done_cyc  = cyc + 1 + FRAME_CYC;
        sb_q.push_back(e);
        $display("issue %s phy=%h reg=%h wdata=%h phy_data=%h ta2=%b", r ? "read " : "write",
                 pa, ra, wd, pd, ta2);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < FRAME_CYC + 16);
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; rw = 1'b0; phy_addr = '0; reg_addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        // Reset wins over a simultaneous start
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_outs", {59'd0, done, mdc, mdio_oe, mdio_o, 1'b0}, 64'h2);
        chk("reset_rdata", 64'(rdata), 64'd0);
        start = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);

        // Abort a read at bit 40
        issue(1'b1, 5'h07, 5'h02, 16'h0000, 16'hBEEF, 1'b0);
        repeat (40 * 2 * CLK_DIV + 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_state", {59'd0, busy, done, mdc, mdio_oe, mdio_o}, 64'h1);
        chk("abort_rdata", 64'(rdata), 64'd0);
        sb_q.delete();
        model_rdata = '0;
        model_rderr = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);

        // Directed write, then read followed by a back-to-back write
        issue(1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        issue(1'b1, 5'h07, 5'h02, 16'h0000, 16'h0141, 1'b0);
        wait_done();
        issue(1'b0, 5'h1F, 5'h1E, 16'hA5C3, 16'h0000, 1'b0);

        // Start pulse at bit 20 of this frame must be ignored
        repeat (20 * 2 * CLK_DIV - 1) @(negedge clk);
        rw = 1'b1; phy_addr = 5'h0A; reg_addr = 5'h15; wdata = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", 64'(busy), 64'd1);
        wait_done();
        repeat (3) @(negedge clk);

`ifdef MDIO_TA_CHECK_EN
        issue(1'b1, 5'h03, 5'h04, 16'h0000, 16'h1234, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);
        issue(1'b1, 5'h03, 5'h05, 16'h0000, 16'h8001, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
`endif

        for (int i = 0; i < 10; i++) begin
            logic        r;
            logic [4:0]  pa, ra;
            logic [15:0] wd, pd;
            r  = 1'($urandom_range(0, 1));
            pa = 5'($urandom);
            ra = 5'($urandom);
            wd = 16'($urandom);
            pd = 16'($urandom);
            issue(r, pa, ra, wd, pd, 1'b0);
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2 * CLK_DIV * 4) @(negedge clk);
        chk("final_idle", 64'(busy), 64'd0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
